// File: rtl/control_pipeline.sv
// Control side of the pipeline: registers the decode-stage control word and carries it
// through ID/EX, EX/MEM and MEM/WB, honouring StallE/FlushE, and counts retired words.
module control_pipeline #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidD,
  input  logic                 RegWriteD,
  input  logic                 MemToRegD,
  input  logic                 MemWriteD,
  input  logic                 ALUSrcD,
  input  logic                 RegDstD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic                 ValidE,
  output logic                 RegWriteE,
  output logic                 MemToRegE,
  output logic                 MemWriteE,
  output logic                 ALUSrcE,
  output logic                 RegDstE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ValidM,
  output logic                 RegWriteM,
  output logic                 MemToRegM,
  output logic                 MemWriteM,
  output logic                 ValidW,
  output logic                 RegWriteW,
  output logic                 MemToRegW,
  output logic [CNT_W-1:0]     RetiredCount
);

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 alu_src;
    logic                 reg_dst;
    logic [ALUCTRL_W-1:0] alu_control;
  } e_word_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } m_word_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
  } w_word_t;

  e_word_t          r_e;
  m_word_t          r_m;
  w_word_t          r_w;
  logic [CNT_W-1:0] r_retired;

  e_word_t w_d_word;
  e_word_t w_e_next;
  m_word_t w_m_next;
  w_word_t w_w_next;

  // An unqualified D word becomes a bubble so stray control bits never reach E.
  always_comb begin
    w_d_word = '0;
    if (ValidD) begin
      w_d_word.valid       = 1'b1;
      w_d_word.reg_write   = RegWriteD;
      w_d_word.mem_to_reg  = MemToRegD;
      w_d_word.mem_write   = MemWriteD;
      w_d_word.alu_src     = ALUSrcD;
      w_d_word.reg_dst     = RegDstD;
      w_d_word.alu_control = ALUControlD;
    end
  end

  always_comb begin
    w_e_next = w_d_word;
    if (FlushE) begin
      w_e_next = '0;
    end else if (StallE) begin
      w_e_next = r_e;
    end
  end

  // While E holds a stalled word, M takes a bubble so that word issues only once.
  always_comb begin
    w_m_next.valid      = r_e.valid;
    w_m_next.reg_write  = r_e.reg_write;
    w_m_next.mem_to_reg = r_e.mem_to_reg;
    w_m_next.mem_write  = r_e.mem_write;
    if (StallE && !FlushE) begin
      w_m_next = '0;
    end
  end

  always_comb begin
    w_w_next.valid      = r_m.valid;
    w_w_next.reg_write  = r_m.reg_write;
    w_w_next.mem_to_reg = r_m.mem_to_reg;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of the stage before it; blocking here would collapse the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e       <= '0;
      r_m       <= '0;
      r_w       <= '0;
      r_retired <= '0;
    end else begin
      r_e       <= w_e_next;
      r_m       <= w_m_next;
      r_w       <= w_w_next;
      r_retired <= r_retired + CNT_W'(r_m.valid);
    end
  end

  assign ValidE       = r_e.valid;
  assign RegWriteE    = r_e.reg_write;
  assign MemToRegE    = r_e.mem_to_reg;
  assign MemWriteE    = r_e.mem_write;
  assign ALUSrcE      = r_e.alu_src;
  assign RegDstE      = r_e.reg_dst;
  assign ALUControlE  = r_e.alu_control;
  assign ValidM       = r_m.valid;
  assign RegWriteM    = r_m.reg_write;
  assign MemToRegM    = r_m.mem_to_reg;
  assign MemWriteM    = r_m.mem_write;
  assign ValidW       = r_w.valid;
  assign RegWriteW    = r_w.reg_write;
  assign MemToRegW    = r_w.mem_to_reg;
  assign RetiredCount = r_retired;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: latency, stall, flush, qualification, async reset
// and counter wrap (counter built 4 bits wide).
module tb_control_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic       ValidD, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [3:0] ALUControlD;
  logic       StallE, FlushE;
  logic       ValidE, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [3:0] ALUControlE;
  logic       ValidM, RegWriteM, MemToRegM, MemWriteM;
  logic       ValidW, RegWriteW, MemToRegW;
  logic [3:0] RetiredCount;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected E-stage vectors {Valid,RegWrite,MemToReg,MemWrite,ALUSrc,RegDst,ALUControl}
  localparam logic [9:0] E_LW = 10'b1110100010;
  localparam logic [9:0] E_SW = 10'b1001100010;
  localparam logic [9:0] E_R  = 10'b1100010010;

  control_pipeline #(.ALUCTRL_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
    .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .ALUControlD(ALUControlD), .StallE(StallE), .FlushE(FlushE),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
    .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .ALUControlE(ALUControlE),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .RetiredCount(RetiredCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] e_vec();
    return {ValidE, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE};
  endfunction

  function automatic logic [3:0] m_vec();
    return {ValidM, RegWriteM, MemToRegM, MemWriteM};
  endfunction

  function automatic logic [2:0] w_vec();
    return {ValidW, RegWriteW, MemToRegW};
  endfunction

  function automatic logic [20:0] all_vec();
    return {e_vec(), m_vec(), w_vec(), RetiredCount};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [9:0] word);
    {ValidD, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD} = word;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_d(10'b0);
    StallE = 1'b0;
    FlushE = 1'b0;
    step();
    if (all_vec() !== 21'b0) begin
      $display("FAIL reset_outputs: got %h want %h", all_vec(), 21'b0); n_bad++;
    end
    n_cmp++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_lw_latency();
    set_d(E_LW);
    step();
    if (e_vec() !== E_LW) begin
      $display("FAIL lw_E: got %b want %b", e_vec(), E_LW); n_bad++;
    end
    n_cmp++;
    set_d(10'b0);
    step();
    if (m_vec() !== 4'b1110) begin
      $display("FAIL lw_M: got %b want %b", m_vec(), 4'b1110); n_bad++;
    end
    n_cmp++;
    step();
    if ({w_vec(), RetiredCount} !== {3'b111, 4'd1}) begin
      $display("FAIL lw_W_cnt: got %b/%0d want 111/1", w_vec(), RetiredCount); n_bad++;
    end
    n_cmp++;
    step();
    if (all_vec() !== {17'b0, 4'd1}) begin
      $display("FAIL lw_drained: got %h want %h", all_vec(), {17'b0, 4'd1}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_stall();
    set_d(E_SW);
    step();
    set_d(10'b0);
    StallE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if ({e_vec(), m_vec()} !== {E_SW, 4'b0000}) begin
        $display("FAIL stall_hold_%0d: got E=%b M=%b want E=%b M=0000", i, e_vec(), m_vec(), E_SW);
        n_bad++;
      end
      n_cmp++;
    end
    StallE = 1'b0;
    step();
    if ({e_vec(), m_vec()} !== {10'b0, 4'b1001}) begin
      $display("FAIL stall_release: got E=%b M=%b want E=0 M=1001", e_vec(), m_vec()); n_bad++;
    end
    n_cmp++;
    step();
    if ({m_vec(), w_vec(), RetiredCount} !== {4'b0000, 3'b100, 4'd2}) begin
      $display("FAIL stall_once: got M=%b W=%b cnt=%0d want M=0000 W=100 cnt=2",
               m_vec(), w_vec(), RetiredCount);
      n_bad++;
    end
    n_cmp++;
    step();
  endtask

  task automatic test_flush_stall();
    set_d(E_R);
    step();
    if (e_vec() !== E_R) begin
      $display("FAIL rtype_E: got %b want %b", e_vec(), E_R); n_bad++;
    end
    n_cmp++;
    set_d(E_LW);
    StallE = 1'b1;
    FlushE = 1'b1;
    step();
    if ({e_vec(), m_vec()} !== {10'b0, 4'b1100}) begin
      $display("FAIL flush_stall: got E=%b M=%b want E=0 M=1100", e_vec(), m_vec()); n_bad++;
    end
    n_cmp++;
    set_d(10'b0);
    StallE = 1'b0;
    FlushE = 1'b0;
    step();
    if ({w_vec(), RetiredCount} !== {3'b110, 4'd3}) begin
      $display("FAIL flush_retire: got W=%b cnt=%0d want W=110 cnt=3", w_vec(), RetiredCount);
      n_bad++;
    end
    n_cmp++;
    step();
  endtask

  task automatic test_unqualified();
    set_d(10'b0100110111);
    for (int i = 0; i < 4; i++) begin
      step();
      if ({RegWriteE, RegWriteM, RegWriteW, ValidE, RetiredCount} !== {4'b0000, 4'd3}) begin
        $display("FAIL unqualified_%0d: got RW E/M/W=%b%b%b ValidE=%b cnt=%0d want 0000/3",
                 i, RegWriteE, RegWriteM, RegWriteW, ValidE, RetiredCount);
        n_bad++;
      end
      n_cmp++;
    end
    set_d(10'b0);
  endtask

  task automatic test_async_reset();
    set_d(E_LW); step();
    set_d(E_R);  step();
    set_d(E_SW); step();
    set_d(10'b0);
    if (all_vec() !== {E_SW, 4'b1100, 3'b111, 4'd4}) begin
      $display("FAIL inflight: got %h want %h", all_vec(), {E_SW, 4'b1100, 3'b111, 4'd4});
      n_bad++;
    end
    n_cmp++;
    #3 reset = 1'b1;
    #1;
    if (all_vec() !== 21'b0) begin
      $display("FAIL async_reset: got %h want 0", all_vec()); n_bad++;
    end
    n_cmp++;
    step();
    reset = 1'b0;
    step();
    if (all_vec() !== 21'b0) begin
      $display("FAIL after_release: got %h want 0", all_vec()); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back_wrap();
    for (int n = 1; n <= 20; n++) begin
      if (n <= 17) set_d(E_LW);
      else         set_d(10'b0);
      step();
      case (n)
        17: begin
          if ({ValidW, RetiredCount} !== {1'b1, 4'd15}) begin
            $display("FAIL wrap_15: got ValidW=%b cnt=%0d want 1/15", ValidW, RetiredCount);
            n_bad++;
          end
          n_cmp++;
        end
        18: begin
          if (RetiredCount !== 4'd0) begin
            $display("FAIL wrap_0: got %0d want 0", RetiredCount); n_bad++;
          end
          n_cmp++;
        end
        19: begin
          if ({ValidW, RetiredCount} !== {1'b1, 4'd1}) begin
            $display("FAIL wrap_1: got ValidW=%b cnt=%0d want 1/1", ValidW, RetiredCount);
            n_bad++;
          end
          n_cmp++;
        end
        20: begin
          if ({ValidW, RetiredCount} !== {1'b0, 4'd1}) begin
            $display("FAIL wrap_idle: got ValidW=%b cnt=%0d want 0/1", ValidW, RetiredCount);
            n_bad++;
          end
          n_cmp++;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_stall();
    test_flush_stall();
    test_unqualified();
    test_async_reset();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
